// File: rtl/pic_pkg.sv
// Shared definitions for the parametric interrupt controller: register map,
// command opcodes, CONFIG bit positions, FSM states and the priority-rank helper.
package pic_pkg;

   localparam logic [1:0] ADDR_CONFIG  = 2'd0;
   localparam logic [1:0] ADDR_MASK    = 2'd1;
   localparam logic [1:0] ADDR_COMMAND = 2'd2;
   localparam logic [1:0] ADDR_AUX     = 2'd3;

   localparam logic [2:0] OP_NS_EOI     = 3'b001;
   localparam logic [2:0] OP_S_EOI      = 3'b011;
   localparam logic [2:0] OP_ROT_NS_EOI = 3'b101;
   localparam logic [2:0] OP_SET_PRIO   = 3'b111;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_WAIT2 = 1'b1
   } pic_state_e;

   function automatic int cfg_level_bit(input int vw);
      return vw;
   endfunction

   function automatic int cfg_aeoi_bit(input int vw);
      return vw + 1;
   endfunction

   function automatic int cfg_arot_bit(input int vw);
      return vw + 2;
   endfunction

   // Rank 0 is the channel just after the pointer; the pointer channel ranks last.
   function automatic int prio_rank(input int ch, input int ptr, input int n);
      int r;
      r = ch + n - ptr - 1;
      return (r >= n) ? (r - n) : r;
   endfunction

endpackage

// File: rtl/parametric_interrupt_controller_if.sv
// CPU-side register bus, request lines and acknowledge/vector handshake of the
// interrupt controller; master is the CPU/peripheral side, slave the controller.
interface parametric_interrupt_controller_if #(
   parameter int NUM_CHANNELS = 8,
   parameter int VECTOR_WIDTH = 8,
   parameter int BUS_WIDTH    = 16
) ();
   logic                    CHIP_SELECT;
   logic                    WRITE;
   logic                    READ;
   logic [1:0]              ADDRESS;
   logic [BUS_WIDTH-1:0]    DATA_IN;
   logic [BUS_WIDTH-1:0]    DATA_OUT;
   logic [NUM_CHANNELS-1:0] INTERRUPT_REQUESTS;
   logic                    INTERRUPT_ACKNOWLEDGE;
   logic                    INTERRUPT;
   logic [VECTOR_WIDTH-1:0] VECTOR_OUT;
   logic                    VECTOR_VALID;

   modport master (
      output CHIP_SELECT, WRITE, READ, ADDRESS, DATA_IN,
      output INTERRUPT_REQUESTS, INTERRUPT_ACKNOWLEDGE,
      input  DATA_OUT, INTERRUPT, VECTOR_OUT, VECTOR_VALID
   );

   modport slave (
      input  CHIP_SELECT, WRITE, READ, ADDRESS, DATA_IN,
      input  INTERRUPT_REQUESTS, INTERRUPT_ACKNOWLEDGE,
      output DATA_OUT, INTERRUPT, VECTOR_OUT, VECTOR_VALID
   );
endinterface

// File: rtl/pic_priority_resolver.sv
// Combinational rotating-priority search: the first set request found walking
// upward from pointer+1 (mod N) wins.
module pic_priority_resolver #(
   parameter int NUM_CHANNELS = 8,
   parameter int IDW          = 3
) (
   input  logic [NUM_CHANNELS-1:0] req,
   input  logic [IDW-1:0]          ptr,
   output logic                    found,
   output logic [IDW-1:0]          id
);
   // Walk from lowest to highest priority so the highest-priority hit is written last.
   always_comb begin
      found = 1'b0;
      id    = {IDW{1'b0}};
      for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
         int             sum;
         logic [IDW-1:0] idx;
         sum   = int'(ptr) + 1 + i;
         idx   = IDW'((sum >= NUM_CHANNELS) ? (sum - NUM_CHANNELS) : sum);
         found = found | req[idx];
         id    = req[idx] ? idx : id;
      end
   end
endmodule

// File: rtl/parametric_interrupt_controller.sv
// 8259A-style interrupt controller: edge/level IRR, mask, rotating nested
// priority, EOI commands, auto-EOI and a two-pulse acknowledge/vector handshake.
module parametric_interrupt_controller
   import pic_pkg::*;
#(
   parameter int NUM_CHANNELS = 8,
   parameter int VECTOR_WIDTH = 8,
   parameter int BUS_WIDTH    = 16
) (
   input logic CLOCK,
   input logic RESET,
   parametric_interrupt_controller_if.slave bus
);
   localparam int IDW      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam int CFGW     = VECTOR_WIDTH + 3;
   localparam int LVL_BIT  = cfg_level_bit(VECTOR_WIDTH);
   localparam int AEOI_BIT = cfg_aeoi_bit(VECTOR_WIDTH);
   localparam int AROT_BIT = cfg_arot_bit(VECTOR_WIDTH);
   localparam logic [IDW-1:0] PTR_RST = IDW'(NUM_CHANNELS - 1);

   logic [NUM_CHANNELS-1:0] irr_r, isr_r, mask_r, req_prev_r;
   logic [NUM_CHANNELS-1:0] irr_n, isr_n, pend_s, edge_s;
   logic [CFGW-1:0]         cfg_r;
   logic [IDW-1:0]          ptr_r, ptr_n, win_r, pend_id_s, isr_id_s, lvl_s;
   logic                    pend_found_s, isr_found_s, spur_r;
   logic                    wr_s, rd_s, cfg_wr_s, mask_wr_s, cmd_wr_s, ack1_s, ack2_s;
   logic                    int_cond_s, int_r, vvalid_r;
   logic [2:0]              op_s;
   logic [BUS_WIDTH-1:0]    data_out_r;
   logic [VECTOR_WIDTH-1:0] vec_r;
   int                      pend_rank_s, isr_rank_s;
   pic_state_e              state_r, state_n;
   logic                    unused_s;

   assign wr_s      = bus.CHIP_SELECT & bus.WRITE;
   assign rd_s      = bus.CHIP_SELECT & bus.READ;
   assign cfg_wr_s  = wr_s && (bus.ADDRESS == ADDR_CONFIG);
   assign mask_wr_s = wr_s && (bus.ADDRESS == ADDR_MASK);
   assign cmd_wr_s  = wr_s && (bus.ADDRESS == ADDR_COMMAND);
   assign op_s      = bus.DATA_IN[2:0];
   assign lvl_s     = bus.DATA_IN[8+IDW-1:8];
   assign ack1_s    = bus.INTERRUPT_ACKNOWLEDGE && (state_r == ST_IDLE);
   assign ack2_s    = bus.INTERRUPT_ACKNOWLEDGE && (state_r == ST_WAIT2);
   assign edge_s    = bus.INTERRUPT_REQUESTS & ~req_prev_r;
   assign pend_s    = irr_r & ~mask_r;
   assign unused_s  = ^bus.DATA_IN;

   pic_priority_resolver #(.NUM_CHANNELS(NUM_CHANNELS), .IDW(IDW)) u_pend_res (
      .req(pend_s), .ptr(ptr_r), .found(pend_found_s), .id(pend_id_s)
   );

   pic_priority_resolver #(.NUM_CHANNELS(NUM_CHANNELS), .IDW(IDW)) u_isr_res (
      .req(isr_r), .ptr(ptr_r), .found(isr_found_s), .id(isr_id_s)
   );

   assign pend_rank_s = prio_rank(int'(pend_id_s), int'(ptr_r), NUM_CHANNELS);
   assign isr_rank_s  = prio_rank(int'(isr_id_s), int'(ptr_r), NUM_CHANNELS);
   assign int_cond_s  = pend_found_s && (!isr_found_s || (pend_rank_s < isr_rank_s));

   // Next IRR/ISR/pointer: EOI first, then acknowledge effects, a CONFIG write overrides all.
   always_comb begin
      irr_n   = cfg_r[LVL_BIT] ? bus.INTERRUPT_REQUESTS : (irr_r | edge_s);
      isr_n   = isr_r;
      ptr_n   = ptr_r;
      state_n = state_r;
      if (bus.INTERRUPT_ACKNOWLEDGE) begin
         state_n = (state_r == ST_IDLE) ? ST_WAIT2 : ST_IDLE;
      end else begin
         state_n = state_r;
      end
      if (cmd_wr_s && ((op_s == OP_NS_EOI) || (op_s == OP_ROT_NS_EOI)) && isr_found_s) begin
         isr_n[isr_id_s] = 1'b0;
         ptr_n = (op_s == OP_ROT_NS_EOI) ? isr_id_s : ptr_n;
      end else if (cmd_wr_s && (op_s == OP_S_EOI)) begin
         isr_n[lvl_s] = 1'b0;
      end else if (cmd_wr_s && (op_s == OP_SET_PRIO)) begin
         ptr_n = lvl_s;
      end else begin
         ptr_n = ptr_n;
      end
      if (ack1_s && pend_found_s) begin
         isr_n[pend_id_s] = 1'b1;
         irr_n[pend_id_s] = 1'b0;
      end else if (ack2_s && cfg_r[AEOI_BIT] && !spur_r) begin
         isr_n[win_r] = 1'b0;
         ptr_n = (cfg_r[AROT_BIT] && !cmd_wr_s) ? win_r : ptr_n;
      end else begin
         isr_n = isr_n;
      end
      if (cfg_wr_s) begin
         irr_n = {NUM_CHANNELS{1'b0}};
         isr_n = {NUM_CHANNELS{1'b0}};
         ptr_n = PTR_RST;
      end else begin
         irr_n = irr_n;
      end
   end

   // All state, the handshake FSM and registered outputs.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         irr_r      <= {NUM_CHANNELS{1'b0}};
         isr_r      <= {NUM_CHANNELS{1'b0}};
         req_prev_r <= {NUM_CHANNELS{1'b0}};
         mask_r     <= {NUM_CHANNELS{1'b1}};
         cfg_r      <= {CFGW{1'b0}};
         ptr_r      <= PTR_RST;
         win_r      <= {IDW{1'b0}};
         spur_r     <= 1'b0;
         state_r    <= ST_IDLE;
         data_out_r <= {BUS_WIDTH{1'b0}};
         int_r      <= 1'b0;
         vec_r      <= {VECTOR_WIDTH{1'b0}};
         vvalid_r   <= 1'b0;
      end else begin
         irr_r      <= irr_n;
         isr_r      <= isr_n;
         ptr_r      <= ptr_n;
         state_r    <= state_n;
         req_prev_r <= cfg_wr_s ? {NUM_CHANNELS{1'b0}} : bus.INTERRUPT_REQUESTS;
         int_r      <= int_cond_s && (state_n == ST_IDLE);
         vvalid_r   <= 1'b0;
         if (mask_wr_s) mask_r <= bus.DATA_IN[NUM_CHANNELS-1:0];
         if (cfg_wr_s)  cfg_r  <= bus.DATA_IN[CFGW-1:0];
         if (rd_s) begin
            case (bus.ADDRESS)
               ADDR_CONFIG:  data_out_r <= BUS_WIDTH'(irr_r);
               ADDR_MASK:    data_out_r <= BUS_WIDTH'(mask_r);
               ADDR_COMMAND: data_out_r <= BUS_WIDTH'(isr_r);
               ADDR_AUX:     data_out_r <= BUS_WIDTH'(cfg_r);
               default:      data_out_r <= {BUS_WIDTH{1'b0}};
            endcase
         end
         case (state_r)
            ST_IDLE: begin
               if (ack1_s) begin
                  win_r  <= pend_found_s ? pend_id_s : PTR_RST;
                  spur_r <= !pend_found_s;
               end
            end
            ST_WAIT2: begin
               if (ack2_s) begin
                  vec_r    <= cfg_r[VECTOR_WIDTH-1:0] + VECTOR_WIDTH'(win_r);
                  vvalid_r <= 1'b1;
               end
            end
            default: begin
               vvalid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.DATA_OUT     = data_out_r;
   assign bus.INTERRUPT    = int_r;
   assign bus.VECTOR_OUT   = vec_r;
   assign bus.VECTOR_VALID = vvalid_r;

endmodule

// File: doc/parametric_interrupt_controller.md
Name: parametric_interrupt_controller

Overview:
Parametrised, fully synchronous successor to the 8259A-style PIC. It has NUM_CHANNELS request lines, edge or level triggering, an interrupt mask, fully nested priority with rotation, specific and non-specific EOI, and an optional auto-EOI. The CPU programs it through a simple strobe register bus, and vectors are delivered through a two-pulse INTERRUPT_ACKNOWLEDGE handshake. It sits between peripheral interrupt sources and the CPU interrupt pin.

Parameters:
NUM_CHANNELS, 8, number of request lines (2..32); channel ID width IDW = clog2(NUM_CHANNELS)
VECTOR_WIDTH, 8, width of the delivered vector
BUS_WIDTH, 16, register data width; must be >= NUM_CHANNELS and >= VECTOR_WIDTH+3

Ports:
CLOCK  in  1  single clock, all logic rising-edge
RESET  in  1  synchronous, active-high
CHIP_SELECT  in  1  high-true register access enable
WRITE  in  1  one-cycle write strobe (qualified by CHIP_SELECT)
READ  in  1  one-cycle read strobe (qualified by CHIP_SELECT)
ADDRESS  in  2  register select
DATA_IN  in  BUS_WIDTH  write data
DATA_OUT  out  BUS_WIDTH  registered read data
INTERRUPT_REQUESTS  in  NUM_CHANNELS  request lines, already synchronous to CLOCK
INTERRUPT_ACKNOWLEDGE  in  1  one-cycle acknowledge pulse from CPU
INTERRUPT  out  1  registered interrupt to CPU
VECTOR_OUT  out  VECTOR_WIDTH  vector, valid with VECTOR_VALID
VECTOR_VALID  out  1  one-cycle vector strobe

Behaviour:
- Reset values: DATA_OUT=0, INTERRUPT=0, VECTOR_OUT=0, VECTOR_VALID=0. Internal state at reset: IRR=0, ISR=0, edge history=0, MASK=all ones, CONFIG=0, rotation pointer=NUM_CHANNELS-1, FSM=IDLE.
- Register map for writes:
  - addr0 CONFIG: [VECTOR_WIDTH-1:0]=vector base, [VW]=level mode, [VW+1]=auto-EOI, [VW+2]=auto-rotate. A CONFIG write also clears IRR, ISR and edge history, and resets the rotation pointer. MASK is unchanged.
  - addr1 MASK: bit i=1 masks channel i.
  - addr2 COMMAND: op in DATA_IN[2:0], level L in DATA_IN[8+IDW-1:8].
    - 001: non-specific EOI; clears the highest-priority ISR bit.
    - 011: specific EOI; clears ISR[L].
    - 101: rotate on non-specific EOI; clears the highest-priority ISR bit and sets the pointer to that channel.
    - 111: set priority; pointer=L.
    - All other ops are ignored.
  - addr3: writes ignored.
- Reads, 1-cycle latency, DATA_OUT held until the next read: addr0=IRR, addr1=MASK, addr2=ISR, addr3=CONFIG. Unused upper bits read 0.
- IRR update:
  - Edge mode: bit i is set on a 0->1 transition of request i versus the previous cycle, and held until acknowledged.
  - Level mode: IRR = current request level. A request dropped before INTA1 is lost.
- Priority: the channel at pointer+1 (mod N) is highest, descending cyclically. The pointer channel is lowest.
- INTERRUPT (registered, 1 cycle after the condition) = a set bit exists in IRR&~MASK whose priority is strictly higher than every set ISR bit.
- FSM:
  - IDLE + INTA pulse -> WAIT2. Freeze winner W = highest unmasked pending request. Set ISR[W] and clear IRR[W]; the edge-mode IRR set for the same cycle is overridden by the clear. If there is no winner, latch spurious (W=N-1, ISR unchanged).
  - WAIT2 + INTA pulse -> IDLE. Next cycle VECTOR_OUT = (base+W) mod 2^VW and VECTOR_VALID=1 for 1 cycle. If auto-EOI is set and the request was not spurious, clear ISR[W]. If auto-rotate is also set, set pointer=W.
  - INTERRUPT is forced 0 while in WAIT2.
- Simultaneous events:
  - A register write in the same cycle as an INTA pulse: INTA uses pre-write state; the write takes effect after.
  - An EOI in the same cycle as INTA1: ISR set by INTA1 wins for W; the EOI still clears its own target if it is different.
- RESET asserted mid-sequence returns to IDLE and drops VECTOR_VALID the next cycle.

Decomposition:
- Shared package pic_pkg holds: register address constants, COMMAND opcode constants, CONFIG bit offsets as functions of VECTOR_WIDTH, and the FSM state enum (IDLE, WAIT2).
- One sub-module, pic_priority_resolver: purely combinational. It takes a request vector plus the rotation pointer and returns a found flag and the winning ID. It is instantiated twice: once for IRR&~MASK and once for ISR.

Test Plan:
- Basic acknowledge: CONFIG=0x020 (base 0x20, edge), MASK=0x00, raise IR1 -> INTERRUPT=1 within 2 cycles. INTA, INTA -> VECTOR_OUT=0x21 with VECTOR_VALID pulse. ISR=0x02. Non-specific EOI -> ISR=0x00.
- Nesting: raise IR5, ack, then raise IR2 -> INTERRUPT=1 (higher priority). Raise IR6 instead -> INTERRUPT stays 0 until EOI.
- Masking and spurious: MASK=0xFF, raise IR3 -> INTERRUPT=0 and IRR reads 0x08. INTA, INTA -> VECTOR_OUT=base+7, ISR=0.
- Rotation: set priority L=3, then raise IR2 and IR5 together -> first vector base+5, second base+2. With auto-EOI+auto-rotate, ISR stays 0 and the pointer follows the served channel.
- Level mode: CONFIG level bit set, assert IR0 then drop it before INTA1 -> INTERRUPT falls and a spurious vector (base+7) is returned.
- Reset in WAIT2: after INTA1, assert RESET -> VECTOR_VALID never pulses, MASK=0xFF, all outputs 0.
